fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage pipeline. It holds the PC, issues instruction reads to the icache, and presents the fetched word plus PC+4 to the IF/ID pipeline register's inputs along with that register's enable and nop (flush) controls. A one-entry holding buffer absorbs an icache hit that arrives while the hazard unit is stalling. Redirects come from branch/jump resolution and override stalls.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset.
HALT_OP, 6'b111111, opcode field (instr[31:26]) that identifies a halt instruction.

Ports:
CLK  in  1  clock, all state updates on the rising edge.
RST  in  1  reset, synchronous, active-high.
ihit  in  1  icache returns valid data for imemaddr this cycle.
imemload  in  32  instruction word from icache, valid when ihit=1.
imemREN  out  1  instruction read request.
imemaddr  out  32  instruction address, always equal to pc.
stall  in  1  hazard unit: IF/ID must hold its contents.
redirect  in  1  branch taken or jump resolved downstream.
redirect_pc  in  32  target address, valid when redirect=1.
iload  out  32  instruction driven to IF/ID input.
cpc  out  32  PC+4 of that instruction, driven to IF/ID input.
ifid_en  out  1  IF/ID load enable.
ifid_nop  out  1  IF/ID flush (inserts bubble).
halted  out  1  fetch has stopped on a halt instruction.

Behaviour:
- Reset (RST=1 at edge): pc<=PC_INIT, state<=FETCH, buf<=0, buffer-valid cleared. While RST=1, outputs are forced: imemREN=0, ifid_en=0, ifid_nop=1, halted=0, iload=0, cpc=0.
- Outputs are combinational from state, pc, buf and inputs. An instruction reaches the IF/ID inputs in the same cycle as ihit. IF/ID captures it at the following edge, so latency is 0 cycles from ihit.
- cpc = pc+4 in FETCH and HOLD, with modulo-2^32 wrap (pc=32'hFFFFFFFC gives cpc=0).
- Priority in every state is: redirect > stall > ihit.
- FETCH state: imemREN=1, imemaddr=pc.
  - redirect=1: pc<=redirect_pc, ifid_nop=1, ifid_en=0. Any ihit this cycle is discarded. Stay in FETCH.
  - stall=1 and ihit=1: buf<=imemload, go to HOLD, ifid_en=0, ifid_nop=0.
  - stall=1 and ihit=0: ifid_en=0, ifid_nop=0, pc unchanged.
  - ihit=1 (no stall): iload=imemload, ifid_en=1, ifid_nop=0, pc<=pc+4. If imemload[31:26]==HALT_OP, go to HALT.
  - ihit=0 (no stall): ifid_nop=1 (bubble), ifid_en=0, pc unchanged.
- HOLD state: imemREN=0, iload=buf.
  - redirect=1: buffered word dropped, pc<=redirect_pc, ifid_nop=1, go to FETCH.
  - stall=1: hold; ifid_en=0, ifid_nop=0.
  - else: ifid_en=1, pc<=pc+4. Go to HALT if buf[31:26]==HALT_OP, otherwise go to FETCH.
- HALT state: imemREN=0, halted=1, ifid_en=0. ifid_nop=1 unless stall=1, in which case ifid_nop=0.
  - redirect=1: pc<=redirect_pc, halted drops next cycle, go to FETCH. This covers a halt fetched on a wrong path.
  - Otherwise remain in HALT until reset.
- ifid_en and ifid_nop are never both 1.
- Reset during an icache miss or in HOLD discards all pending state. The first request after reset uses PC_INIT.

Test Plan:
- Sequential fetch: reset, then ihit=1 every cycle with words 0x20010001, 0x20020002 -> imemaddr 0x0, 0x4, 0x8; cpc 0x4, 0x8; ifid_en=1 each hit cycle; ifid_nop=0.
- Miss: ihit=0 for 3 cycles at pc=0x4, then hit -> imemREN=1 throughout, ifid_nop=1 for 3 cycles, imemaddr stays 0x4, then ifid_en=1 with cpc=0x8.
- Stall buffering: ihit=1 with word 0xAAAA0000 at pc=0x10 while stall=1 for 2 cycles -> HOLD, imemREN=0, ifid_en=0 and ifid_nop=0. Stall drops -> ifid_en=1, iload=0xAAAA0000, cpc=0x14, next imemaddr=0x14.
- Redirect wins: at pc=0x20, redirect=1 to 0x100 with ihit=1 and stall=1 in the same cycle -> ifid_nop=1, hit discarded, next imemaddr=0x100. Repeat from HOLD -> buffer dropped, next imemaddr=0x100.
- Halt: fetch 0xFC000000 at pc=0x30 -> ifid_en=1 that cycle, then halted=1, imemREN=0. Redirect to 0x40 -> halted=0 next cycle, imemaddr=0x40.
- Reset mid-miss: RST=1 during a miss at pc=0x50 -> outputs forced to reset values. After release, imemaddr=PC_INIT and no stale instruction is presented; wrap check with pc=0xFFFFFFFC gives cpc=0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : instruction-fetch stage of the 5-stage pipeline.
//
// Holds the PC, issues icache reads, and drives the fetched word plus PC+4
// onto the IF/ID register inputs together with its load enable and flush
// controls. A one-entry holding buffer captures an icache hit that lands
// while the hazard unit is stalling. Priority in every state is
// redirect > stall > ihit.
//
// Ports
//   CLK, RST      clock, synchronous active-high reset
//   ihit          icache data valid for imemaddr this cycle
//   imemload      instruction word from icache
//   imemREN       instruction read request
//   imemaddr      instruction address (always the current pc)
//   stall         hazard unit: IF/ID must hold
//   redirect      branch/jump resolved downstream; redirect_pc is the target
//   iload, cpc    instruction and its PC+4 driven to IF/ID
//   ifid_en       IF/ID load enable
//   ifid_nop      IF/ID flush (bubble)
//   halted        fetch stopped on a halt instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] iload,
  output logic [31:0] cpc,
  output logic        ifid_en,
  output logic        ifid_nop,
  output logic        halted
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_plus4;

  // Modulo-2^32 wrap is intended: pc 0xFFFFFFFC yields 0.
  assign pc_plus4 = pc_q + 32'd4;
  assign imemaddr = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    imemREN  = 1'b0;
    iload    = '0;
    cpc      = pc_plus4;
    ifid_en  = 1'b0;
    ifid_nop = 1'b0;
    halted   = 1'b0;

    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        iload   = imemload;
        if (redirect) begin
          // Any hit this cycle belongs to the wrong path and is dropped.
          pc_d     = redirect_pc;
          ifid_nop = 1'b1;
        end else if (stall) begin
          if (ihit) begin
            buf_d   = imemload;
            state_d = HOLD;
          end
        end else if (ihit) begin
          ifid_en = 1'b1;
          pc_d    = pc_plus4;
          if (imemload[31:26] == HALT_OP) state_d = HALT;
        end else begin
          ifid_nop = 1'b1;
        end
      end

      HOLD: begin
        iload = buf_q;
        if (redirect) begin
          pc_d     = redirect_pc;
          ifid_nop = 1'b1;
          state_d  = FETCH;
        end else if (!stall) begin
          ifid_en = 1'b1;
          pc_d    = pc_plus4;
          state_d = (buf_q[31:26] == HALT_OP) ? HALT : FETCH;
        end
      end

      HALT: begin
        halted   = 1'b1;
        ifid_nop = !stall;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end
      end

      default: begin
        ifid_nop = 1'b1;
        state_d  = FETCH;
      end
    endcase

    if (RST) begin
      imemREN  = 1'b0;
      ifid_en  = 1'b0;
      ifid_nop = 1'b1;
      halted   = 1'b0;
      iload    = '0;
      cpc      = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed + randomized bench for fetch_unit.
// The stimulus process advances an abstract fetch model (pc, optional held
// word, halted flag) and queues the expected IF outputs for each cycle; a
// separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP = 6'b111111;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, redirect;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, ifid_en, ifid_nop, halted;
  logic [31:0] imemaddr, iload, cpc;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(PC_INIT), .HALT_OP(HALT_OP)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .iload(iload),
    .cpc(cpc), .ifid_en(ifid_en), .ifid_nop(ifid_nop), .halted(halted)
  );

  typedef struct {
    bit          rst;
    bit          ren, en, nop, hlt;
    logic [31:0] addr, il, pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done  = 0;

  // Abstract model state.
  logic [31:0] m_pc;
  bit          m_have;   // a word is waiting to be delivered
  logic [31:0] m_word;
  bit          m_halt;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  // Monitor: one expected record per driven cycle.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imemREN",  {31'd0, imemREN},  {31'd0, e.ren});
      chk("ifid_en",  {31'd0, ifid_en},  {31'd0, e.en});
      chk("ifid_nop", {31'd0, ifid_nop}, {31'd0, e.nop});
      chk("halted",   {31'd0, halted},   {31'd0, e.hlt});
      chk("en_nop_excl", {31'd0, ifid_en & ifid_nop}, 32'd0);
      if (e.rst) begin
        chk("iload_rst", iload, 32'd0);
        chk("cpc_rst",   cpc,   32'd0);
      end else begin
        chk("imemaddr", imemaddr, e.addr);
        if (e.en) begin
          chk("iload", iload, e.il);
          chk("cpc",   cpc,   e.pc4);
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit h, input logic [31:0] w,
                     input bit s, input bit d, input logic [31:0] rp);
    exp_t e;
    RST = r; ihit = h; imemload = w; stall = s; redirect = d; redirect_pc = rp;
    e.rst = r; e.addr = m_pc; e.pc4 = m_pc + 32'd4; e.il = '0;
    e.ren = 0; e.en = 0; e.nop = 0; e.hlt = 0;
    if (r) begin
      e.nop = 1;
    end else if (m_halt) begin
      e.hlt = 1;
      e.nop = !s;
    end else if (m_have) begin
      if (d)       e.nop = 1;
      else if (!s) begin e.en = 1; e.il = m_word; end
    end else begin
      e.ren = 1;
      if (d)        e.nop = 1;
      else if (s)   e.nop = 0;
      else if (h)   begin e.en = 1; e.il = w; end
      else          e.nop = 1;
    end
    exp_q.push_back(e);

    @(posedge CLK);
    if (r) begin
      m_pc = PC_INIT; m_have = 0; m_halt = 0;
    end else if (d) begin
      m_pc = rp; m_have = 0; m_halt = 0;
    end else if (m_halt || s) begin
      if (!m_halt && s && h && !m_have) begin m_have = 1; m_word = w; end
    end else if (m_have) begin
      m_pc = m_pc + 32'd4; m_have = 0; m_halt = (m_word[31:26] == HALT_OP);
    end else if (h) begin
      m_pc = m_pc + 32'd4; m_halt = (w[31:26] == HALT_OP);
    end
    #1;
  endtask

  initial begin
    m_pc = 'x; m_have = 0; m_word = '0; m_halt = 0;
    RST = 1; ihit = 0; imemload = '0; stall = 0; redirect = 0; redirect_pc = '0;
    @(posedge CLK); #1;

    //   rst h  word          s  d  rp
    cyc(1, 0, 32'h0,        0, 0, 32'h0);
    cyc(1, 0, 32'h0,        0, 0, 32'h0);
    // sequential fetch, then miss at 0x4
    cyc(0, 1, 32'h20010001, 0, 0, 32'h0);
    repeat (3) cyc(0, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h20020002, 0, 0, 32'h0);
    // stall buffering at 0x10
    cyc(0, 0, 32'h0,        0, 1, 32'h10);
    cyc(0, 1, 32'hAAAA0000, 1, 0, 32'h0);
    cyc(0, 0, 32'h0,        1, 0, 32'h0);
    cyc(0, 0, 32'h0,        0, 0, 32'h0);
    cyc(0, 1, 32'h20030003, 0, 0, 32'h0);
    // redirect beats stall+hit in FETCH, then from HOLD
    cyc(0, 0, 32'h0,        0, 1, 32'h20);
    cyc(0, 1, 32'h20040004, 1, 1, 32'h100);
    cyc(0, 0, 32'h0,        0, 1, 32'h20);
    cyc(0, 1, 32'h20050005, 1, 0, 32'h0);
    cyc(0, 0, 32'h0,        1, 1, 32'h100);
    cyc(0, 1, 32'h20060006, 0, 0, 32'h0);
    // halt at 0x30, then wrong-path recovery
    cyc(0, 0, 32'h0,        0, 1, 32'h30);
    cyc(0, 1, 32'hFC000000, 0, 0, 32'h0);
    cyc(0, 1, 32'h20070007, 0, 0, 32'h0);
    cyc(0, 0, 32'h0,        1, 0, 32'h0);
    cyc(0, 0, 32'h0,        0, 1, 32'h40);
    cyc(0, 1, 32'h20080008, 0, 0, 32'h0);
    // reset during a miss at 0x50
    cyc(0, 0, 32'h0,        0, 1, 32'h50);
    cyc(0, 0, 32'h0,        0, 0, 32'h0);
    cyc(1, 1, 32'h20090009, 0, 0, 32'h0);
    cyc(0, 0, 32'h0,        0, 0, 32'h0);
    cyc(0, 1, 32'h200A000A, 0, 0, 32'h0);
    // wrap: cpc of 0xFFFFFFFC is 0
    cyc(0, 0, 32'h0,        0, 1, 32'hFFFFFFFC);
    cyc(0, 1, 32'h200B000B, 0, 0, 32'h0);
    cyc(0, 1, 32'h200C000C, 0, 0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, h, s, d;
      logic [31:0] w, rp;
      r = ($urandom_range(0, 99) == 0);
      h = ($urandom_range(0, 2) != 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 11) == 0);
      w = $urandom;
      if ($urandom_range(0, 9) == 0) w[31:26] = HALT_OP;
      rp = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFFC;
      cyc(r, h, w, s, d, rp);
    end

    RST = 1; ihit = 0; stall = 0; redirect = 0;
    // Bounded drain of the scoreboard.
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge CLK);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
